next_addr_seq: RTL and testbench

NEXT_ADDR_SEQ -- requirements
Module: next_addr_seq

---
 rtl/next_addr_seq.sv | 159 +++++++++++++++
 tb/tb_next_addr_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/next_addr_seq.sv
// Next-PC sequencer: increment/jump/branch/jump-register selection plus a
// circular return-address stack that overwrites its oldest entry when full.
module next_addr_seq #(
  parameter int AW = 30,
  parameter int JW = 26,
  parameter int RAS_DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          zFlag,
  input  logic          carryFlag,
  input  logic          signFlag,
  input  logic          overflowFlag,
  input  logic [AW-1:0] register,
  input  logic [JW-1:0] jta,
  input  logic [15:0]   imm,
  input  logic [2:0]    brType,
  input  logic [1:0]    PCSel,
  input  logic          call,
  input  logic          ret,
  input  logic          stall,
  output logic [AW-1:0] PC,
  output logic [AW-1:0] IncrPC,
  output logic [AW-1:0] NextPC,
  output logic          taken,
  output logic          ras_full,
  output logic          ras_empty,
  output logic          ret_miss
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

  logic [AW-1:0] pc_r;
  logic [AW-1:0] ras_r [RAS_DEPTH];
  logic [PW-1:0] sp_r;
  logic [PW-1:0] sp_nxt_s;
  logic [PW-1:0] top_idx_s;
  logic [PW-1:0] wr_idx_s;
  logic [PW:0]   cnt_r;
  logic [PW:0]   cnt_nxt_s;
  logic          ret_miss_r;
  logic          ret_miss_nxt_s;
  logic          cond_s;
  logic          call_act_s;
  logic          ret_act_s;
  logic          wr_en_s;
  logic [AW-1:0] jump_s;
  logic [AW-1:0] imm_ext_s;

  // sp_r points at the next free slot, so the top lives one below it
  assign top_idx_s = sp_r - PW'(1);
  assign IncrPC    = pc_r + AW'(1);
  assign imm_ext_s = AW'($signed(imm));
  assign PC        = pc_r;
  assign ret_miss  = ret_miss_r;
  assign ras_empty = (cnt_r == (PW+1)'(0));
  assign ras_full  = (cnt_r == DEPTH_C);

  if (JW == AW) begin : g_full_jump
    assign jump_s = jta;
  end else begin : g_part_jump
    assign jump_s = {pc_r[AW-1:JW], jta};
  end

  // Branch condition decode and next-PC selection
  always_comb begin
    cond_s = 1'b0;
    taken  = 1'b0;
    NextPC = IncrPC;
    case (brType)
      3'd0:    cond_s = zFlag;
      3'd1:    cond_s = ~zFlag;
      3'd2:    cond_s = signFlag ^ overflowFlag;
      3'd3:    cond_s = ~(signFlag ^ overflowFlag);
      3'd4:    cond_s = carryFlag;
      3'd5:    cond_s = ~carryFlag;
      3'd6:    cond_s = 1'b1;
      default: cond_s = 1'b0;
    endcase
    case (PCSel)
      2'd0: NextPC = IncrPC;
      2'd1: NextPC = jump_s;
      2'd2: begin
        taken = cond_s;
        if (cond_s) begin
          NextPC = IncrPC + imm_ext_s;
        end else begin
          NextPC = IncrPC;
        end
      end
      2'd3: begin
        if (ret && !ras_empty) begin
          NextPC = ras_r[top_idx_s];
        end else begin
          NextPC = register;
        end
      end
      default: NextPC = IncrPC;
    endcase
  end

  assign call_act_s = call & ~stall & ((PCSel == 2'd1) | (PCSel == 2'd3));
  assign ret_act_s  = ret & ~stall & (PCSel == 2'd3);

  // Stack pointer/count update; a combined call+ret rewrites the popped slot
  always_comb begin
    sp_nxt_s       = sp_r;
    cnt_nxt_s      = cnt_r;
    wr_en_s        = 1'b0;
    wr_idx_s       = sp_r;
    ret_miss_nxt_s = ret_act_s & ras_empty;
    if (call_act_s && ret_act_s && !ras_empty) begin
      wr_en_s  = 1'b1;
      wr_idx_s = top_idx_s;
    end else if (call_act_s) begin
      wr_en_s  = 1'b1;
      wr_idx_s = sp_r;
      sp_nxt_s = sp_r + PW'(1);
      if (ras_full) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + (PW+1)'(1);
      end
    end else if (ret_act_s && !ras_empty) begin
      sp_nxt_s  = top_idx_s;
      cnt_nxt_s = cnt_r - (PW+1)'(1);
    end else begin
      sp_nxt_s  = sp_r;
      cnt_nxt_s = cnt_r;
    end
  end

  // PC, stack pointer/count and miss pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      sp_r       <= '0;
      cnt_r      <= '0;
      ret_miss_r <= 1'b0;
    end else begin
      if (!stall) begin
        pc_r <= NextPC;
      end
      sp_r       <= sp_nxt_s;
      cnt_r      <= cnt_nxt_s;
      ret_miss_r <= ret_miss_nxt_s;
    end
  end

  // Stack storage carries no reset; empty entries are never read out
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      ras_r[wr_idx_s] <= IncrPC;
    end
  end

endmodule

// File: tb/tb_next_addr_seq.sv
// Bench for next_addr_seq: directed scenarios plus random traffic checked
// against a queue-based model of the PC and return-address stack.
module tb_next_addr_seq;

  localparam int AW = 30;
  localparam int JW = 26;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RST_PC = {AW{1'b0}};

  logic clk, rst_n;
  logic zFlag, carryFlag, signFlag, overflowFlag;
  logic [AW-1:0] register;
  logic [JW-1:0] jta;
  logic [15:0] imm;
  logic [2:0] brType;
  logic [1:0] PCSel;
  logic call, ret, stall;
  logic [AW-1:0] PC, IncrPC, NextPC;
  logic taken, ras_full, ras_empty, ret_miss;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] m_pc;
  logic m_miss;
  logic [AW-1:0] m_q[$];

  next_addr_seq #(.AW(AW), .JW(JW), .RAS_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .zFlag(zFlag), .carryFlag(carryFlag),
    .signFlag(signFlag), .overflowFlag(overflowFlag), .register(register),
    .jta(jta), .imm(imm), .brType(brType), .PCSel(PCSel), .call(call),
    .ret(ret), .stall(stall), .PC(PC), .IncrPC(IncrPC), .NextPC(NextPC),
    .taken(taken), .ras_full(ras_full), .ras_empty(ras_empty), .ret_miss(ret_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_cond();
    case (brType)
      3'd0: return zFlag;
      3'd1: return !zFlag;
      3'd2: return signFlag != overflowFlag;
      3'd3: return signFlag == overflowFlag;
      3'd4: return carryFlag;
      3'd5: return !carryFlag;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [AW-1:0] model_next(input logic tk);
    logic [AW-1:0] inc;
    int off;
    inc = m_pc + 1;
    off = $signed(imm);
    case (PCSel)
      2'd0: return inc;
      2'd1: return ((m_pc >> JW) << JW) | AW'(jta);
      2'd2: return tk ? inc + off[AW-1:0] : inc;
      default: return (ret && m_q.size() > 0) ? m_q[$] : register;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    m_q.delete();
    m_miss = 1'b0;
  endtask

  // One clock: check combinational view, take the edge, advance the model.
  task automatic step();
    logic tk;
    logic [AW-1:0] nx, inc;
    logic do_call, do_ret;
    #1;
    tk = (PCSel == 2'd2) ? model_cond() : 1'b0;
    nx = model_next(tk);
    inc = m_pc + 1;
    check("pc", PC, m_pc);
    check("incr", IncrPC, inc);
    check("next", NextPC, nx);
    check("taken", taken, tk);
    check("full", ras_full, m_q.size() == DEPTH);
    check("empty", ras_empty, m_q.size() == 0);
    check("miss", ret_miss, m_miss);
    @(posedge clk);
    #1;
    if (stall) begin
      m_miss = 1'b0;
    end else begin
      do_ret = ret && PCSel == 2'd3;
      do_call = call && (PCSel == 2'd1 || PCSel == 2'd3);
      m_miss = do_ret && m_q.size() == 0;
      if (do_ret && m_q.size() > 0) void'(m_q.pop_back());
      if (do_call) begin
        if (m_q.size() == DEPTH) void'(m_q.pop_front());
        m_q.push_back(inc);
      end
      m_pc = nx;
    end
  endtask

  task automatic set_pc(input logic [AW-1:0] v);
    PCSel = 2'd3; register = v; call = 1'b0; ret = 1'b0; stall = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; zFlag = 1'b0; carryFlag = 1'b0; signFlag = 1'b0; overflowFlag = 1'b0;
    register = '0; jta = '0; imm = 16'h0; brType = 3'd0; PCSel = 2'd0;
    call = 1'b0; ret = 1'b0; stall = 1'b0;
    model_reset();
    #12;
    check("rst_pc", PC, 0);
    check("rst_empty", ras_empty, 1);
    check("rst_full", ras_full, 0);
    check("rst_miss", ret_miss, 0);
    rst_n = 1'b1;

    // sequential increment after reset
    for (int i = 1; i <= 3; i++) begin
      step();
      check("inc_pc", PC, i);
    end

    // conditional branch, taken and not taken
    set_pc(30'h10);
    PCSel = 2'd2; brType = 3'd0; imm = 16'hFFFC; zFlag = 1'b1;
    #1 check("br_taken", taken, 1);
    step();
    check("br_pc", PC, 30'h0D);
    set_pc(30'h10);
    PCSel = 2'd2; zFlag = 1'b0;
    #1 check("br_nt", taken, 0);
    step();
    check("br_nt_pc", PC, 30'h11);

    // jump keeps upper bits; increment wraps
    set_pc(30'h20000005);
    PCSel = 2'd1; jta = 26'h123;
    step();
    check("jmp_pc", PC, 30'h20000123);
    set_pc(30'h3FFFFFFF);
    PCSel = 2'd0;
    step();
    check("wrap_pc", PC, 0);

    // five calls overflow a 4-deep stack, then five returns
    for (int i = 1; i <= 5; i++) begin
      set_pc(30'(i * 32'h100));
      PCSel = 2'd1; jta = 26'h40; call = 1'b1;
      step();
      call = 1'b0;
      if (i == 4) check("full4", ras_full, 1);
    end
    PCSel = 2'd3; register = 30'h7; ret = 1'b1;
    for (int i = 5; i >= 2; i--) begin
      step();
      check("ret_pc", PC, 30'(i * 32'h100 + 1));
    end
    step();
    check("ret_empty_pc", PC, 30'h7);
    check("ret_miss1", ret_miss, 1);
    check("ret_empty", ras_empty, 1);
    ret = 1'b0; PCSel = 2'd0;
    step();
    check("ret_miss0", ret_miss, 0);

    // stall holds everything
    set_pc(30'h7);
    PCSel = 2'd1; jta = 26'h55; call = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", PC, 30'h7);
      check("stall_empty", ras_empty, 1);
    end
    stall = 1'b0;
    step();
    check("unstall_pc", PC, 30'h55);
    check("unstall_cnt", ras_empty, 0);
    jta = 26'h66; step();
    jta = 26'h77; step();
    call = 1'b0; PCSel = 2'd0;

    // asynchronous reset between edges with three entries stacked
    #1 rst_n = 1'b0;
    #1;
    check("async_pc", PC, 0);
    check("async_empty", ras_empty, 1);
    model_reset();
    #1 rst_n = 1'b1;
    step();
    check("post_rst_pc", PC, 1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      zFlag = 1'($urandom()); carryFlag = 1'($urandom());
      signFlag = 1'($urandom()); overflowFlag = 1'($urandom());
      register = AW'($urandom()); jta = JW'($urandom()); imm = 16'($urandom());
      brType = 3'($urandom()); PCSel = 2'($urandom());
      call = ($urandom_range(0, 2) == 0); ret = ($urandom_range(0, 1) == 0);
      stall = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
